// File: rtl/seq_shift_pkg.sv
// seq_shift_pkg: shared types for the seq_shift_register block.
//   sh_mode_t - shift mode encoding (matches the 2-bit mode input)
//   state_t   - burst sequencer states
package seq_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSR = 2'b00,  // logical right, si enters at MSB
    SH_LSL = 2'b01,  // logical left,  si enters at LSB
    SH_ASR = 2'b10,  // arithmetic right, MSB replicated
    SH_ROR = 2'b11   // rotate right (LSR when rotate support is compiled out)
  } sh_mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_shift_register_shift_step.sv
// shift_step: combinational single-position shifter.
// Macro: SEQ_SHIFT_ROTATE_EN enables the rotate-right path for SH_ROR;
//        without it SH_ROR falls through to logical right.
// Ports:
//   i_q    - current register value
//   i_si   - serial input for the logical modes
//   i_mode - shift mode
//   o_q    - shifted value
//   o_so   - bit shifted out
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_si,
  input  sh_mode_t         i_mode,
  output logic [WIDTH-1:0] o_q,
  output logic             o_so
);

  always_comb begin
    o_q  = {i_si, i_q[WIDTH-1:1]};
    o_so = i_q[0];
    case (i_mode)
      SH_LSL: begin
        o_q  = {i_q[WIDTH-2:0], i_si};
        o_so = i_q[WIDTH-1];
      end
      SH_ASR: o_q = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
`ifdef SEQ_SHIFT_ROTATE_EN
      SH_ROR: o_q = {i_q[0], i_q[WIDTH-1:1]};
`endif
      default: ;  // SH_LSR (and SH_ROR without rotate) keep the defaults
    endcase
  end

endmodule

// File: rtl/seq_shift_register.sv
// seq_shift_register: multi-mode shift register with burst sequencer.
// Macro: SEQ_SHIFT_ROTATE_EN (see shift_step) selects rotate for mode 11.
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   ld, d            - parallel load (highest priority in IDLE)
//   mode, si         - shift mode and serial input
//   step             - single shift in IDLE
//   start, amount    - burst of `amount` shifts; amount=0 goes straight to DONE
//   q, so            - register contents, last bit shifted out
//   busy, done       - burst in progress / one-cycle completion pulse
module seq_shift_register
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             si,
  input  logic             step,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  sh_mode_t         r_mode, w_mode_nxt;
  logic [WIDTH-1:0] r_q;
  logic             r_so;

  logic             w_do_load, w_do_shift;
  sh_mode_t         w_mode_sel;
  logic [WIDTH-1:0] w_q_sh;
  logic             w_so_sh;

  // One shifter serves both single steps (live mode) and bursts (latched mode).
  assign w_mode_sel = (r_state == S_SHIFT) ? r_mode : sh_mode_t'(mode);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_q    (r_q),
    .i_si   (si),
    .i_mode (w_mode_sel),
    .o_q    (w_q_sh),
    .o_so   (w_so_sh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= SH_LSR;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_do_load   = 1'b0;
    w_do_shift  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ld) begin
          w_do_load = 1'b1;
        end else if (start) begin
          if (amount != '0) begin
            w_mode_nxt  = sh_mode_t'(mode);
            w_cnt_nxt   = amount;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else if (step) begin
          w_do_shift = 1'b1;
        end
      end
      S_SHIFT: begin
        w_do_shift = 1'b1;
        w_cnt_nxt  = r_cnt - 1'b1;
        // <= guards against a stuck burst should cnt ever be 0 here
        if (r_cnt <= CNT_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      r_so <= 1'b0;
    end else if (w_do_load) begin
      r_q <= d;
    end else if (w_do_shift) begin
      r_q  <= w_q_sh;
      r_so <= w_so_sh;
    end
  end

  assign q    = r_q;
  assign so   = r_so;
  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_shift_register.sv
module tb_seq_shift_register;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ld, si, step, start;
  logic [WIDTH-1:0] d;
  logic [1:0]       mode;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             so, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .d(d), .mode(mode), .si(si),
    .step(step), .start(start), .amount(amount),
    .q(q), .so(so), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic eso,
                         input logic ebusy, input logic edone);
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".so"},   32'(so),   32'(eso));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    chk({tag, ".done"}, 32'(done), 32'(edone));
  endtask

  initial begin
    rst_n = 1'b0; ld = 0; si = 0; step = 0; start = 0; d = '0; mode = 2'b00; amount = '0;
    #12;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Load + logical-right burst of 3 with si=1
    ld = 1; d = 8'hB4; tick(); ld = 0;
    chk_all("ld_b4", 8'hB4, 1'b0, 1'b0, 1'b0);
    mode = 2'b00; si = 1; start = 1; amount = 4'd3; tick(); start = 0;
    chk_all("lsr_c1", 8'hB4, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("lsr_c2", 8'hDA, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("lsr_c3", 8'hED, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("lsr_c4", 8'hF6, 1'b1, 1'b0, 1'b1);
    tick(); chk_all("lsr_idle", 8'hF6, 1'b1, 1'b0, 1'b0);

    // Arithmetic-right burst of 2
    ld = 1; d = 8'h90; tick(); ld = 0;
    mode = 2'b10; si = 0; start = 1; amount = 4'd2; tick(); start = 0;
    tick(); chk_all("asr_c2", 8'hC8, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("asr_done", 8'hE4, 1'b0, 1'b0, 1'b1);
    tick();

    // Single steps
    ld = 1; d = 8'h81; tick(); ld = 0;
    mode = 2'b01; si = 0; step = 1; tick(); step = 0;
    chk_all("step_lsl", 8'h02, 1'b1, 1'b0, 1'b0);
    mode = 2'b11; step = 1; tick(); step = 0;
    chk_all("step_m11_a", 8'h01, 1'b0, 1'b0, 1'b0);
    ld = 1; d = 8'h81; tick(); ld = 0;
    step = 1; tick(); step = 0;
`ifdef SEQ_SHIFT_ROTATE_EN
    chk_all("step_m11_b", 8'hC0, 1'b1, 1'b0, 1'b0);
`else
    chk_all("step_m11_b", 8'h40, 1'b1, 1'b0, 1'b0);
`endif

    // Zero-length burst: done next cycle, no shift
    ld = 1; d = 8'h5A; tick(); ld = 0;
    mode = 2'b00; si = 1; start = 1; amount = 4'd0; tick(); start = 0;
    chk_all("zero_done", 8'h5A, 1'b1, 1'b0, 1'b1);
    tick(); chk_all("zero_idle", 8'h5A, 1'b1, 1'b0, 1'b0);

    // 5-shift LSL burst; ld/mode/step changes mid-burst must be ignored
    ld = 1; d = 8'h3C; tick(); ld = 0;
    mode = 2'b01; si = 1; start = 1; amount = 4'd5; tick(); start = 0;
    ld = 1; d = 8'hFF; mode = 2'b00; step = 1; tick(); ld = 0; step = 0;
    chk_all("ign_s1", 8'h79, 1'b0, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    chk_all("ign_done", 8'h9F, 1'b1, 1'b0, 1'b1);
    tick();

    // Asynchronous reset at shift 2 of 6
    ld = 1; d = 8'hA5; tick(); ld = 0;
    mode = 2'b00; si = 0; start = 1; amount = 4'd6; tick(); start = 0;
    tick(); tick();
    chk_all("rst_pre", 8'h29, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); chk_all("rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    mode = 2'b00; si = 1; start = 1; amount = 4'd1; tick(); start = 0;
    chk_all("post_busy", 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("post_done", 8'h80, 1'b0, 1'b0, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
